mpi_link_rx: RTL and testbench

MPI_LINK_RX -- requirements
Module: mpi_link_rx

---
 rtl/mpi_link_pkg.sv | 13 +
 rtl/mpi_link_rx_if.sv | 25 ++
 rtl/mpi_link_rx_fifo.sv | 62 ++++++
 rtl/mpi_link_rx.sv | 81 ++++++++
 tb/tb_mpi_link_rx.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mpi_link_pkg.sv
// Shared types and defaults for the MPI link receive slice.
package mpi_link_pkg;

   localparam int unsigned DATA_W_DEF = 64;
   localparam int unsigned DEPTH_DEF  = 4;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/mpi_link_rx_if.sv
// Link-side and consumer-side handshake bundle for mpi_link_rx.
interface mpi_link_rx_if
   import mpi_link_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) ();

   logic              link_valid;
   logic [DATA_W-1:0] link_data;
   logic              link_yummy;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;

   modport master (
      output link_valid, link_data, out_ready,
      input  link_yummy, out_valid, out_data
   );

   modport slave (
      input  link_valid, link_data, out_ready,
      output link_yummy, out_valid, out_data
   );

endinterface

// File: rtl/mpi_link_rx_fifo.sv
// Receive buffer storage: circular array with wrap-around pointers and occupancy count.
module mpi_link_rx_fifo #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 64
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [DATA_W-1:0]          wdata_i,
   output logic [DATA_W-1:0]          rdata_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wptr_q, wptr_d;
   logic [AW-1:0]     rptr_q, rptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              full, wr_en, rd_en;

   assign full    = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   // A push into a full buffer still lands when the head leaves on the same edge.
   assign rd_en   = pop_i && !empty_o;
   assign wr_en   = push_i && (!full || rd_en);
   assign rdata_o = mem_q[rptr_q];
   assign count_o = count_q;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (wr_en) wptr_d = wptr_q + AW'(1);
      if (rd_en) rptr_d = rptr_q + AW'(1);
      unique case ({wr_en, rd_en})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wptr_q] <= wdata_i;
   end

endmodule

// File: rtl/mpi_link_rx.sv
// Credit-based MPI link receiver: buffers remote beats, returns yummy credits, drains on finalize.
// Optional sticky error flag for overflow/late beats: define MPI_LINK_RX_ERR_EN.
module mpi_link_rx
   import mpi_link_pkg::*;
#(
   parameter int unsigned DEPTH  = DEPTH_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic                   clk_i,
   input  logic                   rstn_i,
   mpi_link_rx_if.slave           link_if,
   input  logic                   finalize_i,
   output logic                   done_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   err_o
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   state_e state_q, state_d;
   logic   yummy_q;
   logic   push_req, pop, empty;

   assign push_req = link_if.link_valid && (state_q != DONE);
   assign pop      = !empty && link_if.out_ready;

   mpi_link_rx_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .push_i  (push_req),
      .pop_i   (link_if.out_ready),
      .wdata_i (link_if.link_data),
      .rdata_o (link_if.out_data),
      .count_o (count_o),
      .empty_o (empty)
   );

   assign link_if.out_valid  = !empty;
   assign link_if.link_yummy = yummy_q;
   assign done_o             = (state_q == DONE);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:     if (finalize_i) state_d = DRAIN;
         DRAIN:   if ((count_o == '0) && !link_if.link_valid) state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= RUN;
         yummy_q <= 1'b0;
      end else begin
         state_q <= state_d;
         yummy_q <= pop;
      end
   end

`ifdef MPI_LINK_RX_ERR_EN
   logic err_q, overflow, late_beat;

   assign overflow  = push_req && (count_o == CW'(DEPTH)) && !pop;
   assign late_beat = link_if.link_valid && (state_q == DONE);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) err_q <= 1'b0;
      else         err_q <= err_q | overflow | late_beat;
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mpi_link_rx.sv
// Randomized and directed checks of mpi_link_rx against a queue-based reference model.
module tb_mpi_link_rx;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned DATA_W = 64;

   logic       clk  = 1'b0;
   logic       rstn = 1'b0;
   logic       fin  = 1'b0;
   logic       done;
   logic [2:0] count;
   logic       err;

   mpi_link_rx_if #(.DATA_W(DATA_W)) lif ();

   mpi_link_rx #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) dut (
      .clk_i      (clk),
      .rstn_i     (rstn),
      .link_if    (lif),
      .finalize_i (fin),
      .done_o     (done),
      .count_o    (count),
      .err_o      (err)
   );

   always #5 clk = ~clk;

   // Reference model: buffer contents as a queue plus lifecycle flags.
   logic [63:0] mq [$];
   bit          m_drain, m_done, m_yummy, m_err;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   bit          err_en;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_drain = 1'b0;
      m_done  = 1'b0;
      m_yummy = 1'b0;
      m_err   = 1'b0;
   endtask

   task automatic check_outputs();
      check("count", 64'(count), 64'(mq.size()));
      check("out_valid", 64'(lif.out_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) check("out_data", lif.out_data, mq[0]);
      check("yummy", 64'(lif.link_yummy), 64'(m_yummy));
      check("done", 64'(done), 64'(m_done));
      check("err", 64'(err), 64'(m_err));
   endtask

   // One clock: drive inputs, check outputs mid-cycle, advance model across the edge.
   task automatic cycle(input bit v, input logic [63:0] d, input bit rdy, input bit f);
      bit pop, push, ovf, late, nd;
      lif.link_valid = v;
      lif.link_data  = d;
      lif.out_ready  = rdy;
      fin            = f;
      @(negedge clk);
      check_outputs();
      pop  = (mq.size() != 0) && rdy;
      push = v && !m_done;
      ovf  = push && (mq.size() == DEPTH) && !pop;
      late = v && m_done;
      nd   = m_done || (m_drain && (mq.size() == 0) && !v);
      if (pop) void'(mq.pop_front());
      if (push && !ovf) mq.push_back(d);
      m_yummy = pop;
      if (f) m_drain = 1'b1;
      m_done = nd;
      if (err_en && (ovf || late)) m_err = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      lif.link_valid = 1'b0;
      lif.link_data  = '0;
      lif.out_ready  = 1'b0;
      fin            = 1'b0;
   endtask

   // Asserted between edges so the clear must come from the asynchronous path.
   task automatic do_reset(input string tag);
      idle_inputs();
      #2;
      rstn = 1'b0;
      #1;
      check({tag, "_rst_count"}, 64'(count), 64'd0);
      check({tag, "_rst_valid"}, 64'(lif.out_valid), 64'd0);
      check({tag, "_rst_yummy"}, 64'(lif.link_yummy), 64'd0);
      check({tag, "_rst_done"}, 64'(done), 64'd0);
      check({tag, "_rst_err"}, 64'(err), 64'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit          fin_lvl;
      bit          v, r;
      logic [63:0] d;
      int unsigned rbias;

`ifdef MPI_LINK_RX_ERR_EN
      err_en = 1'b1;
`else
      err_en = 1'b0;
`endif
      idle_inputs();
      model_reset();
      #2;
      check("por_count", 64'(count), 64'd0);
      check("por_valid", 64'(lif.out_valid), 64'd0);
      check("por_done", 64'(done), 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // Three beats held, then drained in order with lagging yummies.
      cycle(1, 64'hA1, 0, 0);
      cycle(1, 64'hA2, 0, 0);
      cycle(1, 64'hA3, 0, 0);
      check("d_hold_count", 64'(count), 64'd3);
      check("d_hold_data", lif.out_data, 64'hA1);
      check("d_hold_yummy", 64'(lif.link_yummy), 64'd0);
      for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0);
      check("d_pop_yummy_last", 64'(lif.link_yummy), 64'd1);
      cycle(0, '0, 0, 0);
      check("d_pop_count", 64'(count), 64'd0);

      // Overflow drop, then full push+pop.
      for (int i = 0; i < 4; i++) cycle(1, 64'hB0 + 64'(i), 0, 0);
      cycle(1, 64'hFF, 0, 0);
      check("d_ovf_count", 64'(count), 64'd4);
      check("d_ovf_data", lif.out_data, 64'hB0);
      check("d_ovf_err", 64'(err), 64'(err_en));
      check("d_ovf_yummy", 64'(lif.link_yummy), 64'd0);
      cycle(1, 64'h55, 1, 0);
      check("d_full_pp_count", 64'(count), 64'd4);
      check("d_full_pp_yummy", 64'(lif.link_yummy), 64'd1);
      for (int i = 0; i < 4; i++) cycle(0, '0, 1, 0);
      cycle(0, '0, 0, 0);
      check("d_full_drain_count", 64'(count), 64'd0);
      do_reset("d1");

      // Finalize with two entries held, then a late beat in DONE.
      cycle(1, 64'hC1, 0, 0);
      cycle(1, 64'hC2, 0, 0);
      cycle(0, '0, 0, 1);
      cycle(0, '0, 0, 1);
      check("d_drain_done_lo", 64'(done), 64'd0);
      cycle(0, '0, 1, 1);
      cycle(0, '0, 1, 1);
      check("d_drain_done_lo2", 64'(done), 64'd0);
      cycle(0, '0, 0, 1);
      check("d_drain_done_hi", 64'(done), 64'd1);
      cycle(1, 64'hDD, 0, 1);
      check("d_late_count", 64'(count), 64'd0);
      check("d_late_err", 64'(err), 64'(err_en));
      cycle(0, '0, 0, 1);
      do_reset("d2");

      // Finalize while empty reaches DONE one cycle after DRAIN.
      cycle(0, '0, 0, 1);
      check("d_empty_fin_drain", 64'(done), 64'd0);
      cycle(0, '0, 0, 1);
      check("d_empty_fin_done", 64'(done), 64'd1);
      do_reset("d3");

      // Reset with entries buffered discards them.
      cycle(1, 64'hE1, 0, 0);
      cycle(1, 64'hE2, 0, 0);
      cycle(1, 64'hE3, 0, 0);
      do_reset("d4");
      cycle(1, 64'hF1, 0, 0);
      check("d_after_rst_count", 64'(count), 64'd1);
      check("d_after_rst_data", lif.out_data, 64'hF1);
      cycle(0, '0, 1, 0);
      cycle(0, '0, 0, 0);

      // Randomized traffic with varying consumer pressure, finalize and resets.
      fin_lvl = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ((m_done && ($urandom_range(7) == 0)) || ($urandom_range(599) == 0)) begin
            do_reset("rnd");
            fin_lvl = 1'b0;
         end
         if ($urandom_range(299) == 0) fin_lvl = 1'b1;
         rbias = (i / 256) % 3;
         v = ($urandom_range(3) != 0);
         d = {$urandom(), $urandom()};
         case (rbias)
            0:       r = ($urandom_range(3) == 0);
            1:       r = ($urandom_range(1) == 0);
            default: r = ($urandom_range(3) != 0);
         endcase
         cycle(v, d, r, fin_lvl);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
